// File: rtl/imm_encoder.sv
// RV32 immediate encoder: scatters an immediate into an I/S/B/J/U template word.
// Optional saturating error counter enabled by IMM_ENCODER_ERR_CNT_EN.
module imm_encoder #(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           imm_src,
  input  logic [31:0]          imm,
  input  logic [31:0]          base_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          inst,
  output logic                 range_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0] SRC_I = 3'd0;
  localparam logic [2:0] SRC_S = 3'd1;
  localparam logic [2:0] SRC_B = 3'd2;
  localparam logic [2:0] SRC_J = 3'd3;
  localparam logic [2:0] SRC_U = 3'd4;

  logic        s1_valid;
  logic        s1_err;
  logic [2:0]  s1_src;
  logic [31:0] s1_imm;
  logic [31:0] s1_base;
  logic        s1_advance;

  logic        s2_valid;
  logic        s2_err;
  logic [31:0] s2_inst;

  logic        in_err;
  logic [31:0] pack;

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;

  // sign-extension checks: upper bits must all match the field's sign bit
  always_comb begin
    in_err = 1'b1;
    unique case (1'b1)
      (imm_src == SRC_I) || (imm_src == SRC_S):
        in_err = !(&imm[31:11] || ~|imm[31:11]);
      (imm_src == SRC_B):
        in_err = !(&imm[31:12] || ~|imm[31:12]) || imm[0];
      (imm_src == SRC_J):
        in_err = !(&imm[31:20] || ~|imm[31:20]) || imm[0];
      (imm_src == SRC_U):
        in_err = |imm[11:0];
      default:
        in_err = 1'b1;
    endcase
  end

  always_comb begin
    pack = s1_base;
    unique case (1'b1)
      (s1_src == SRC_I): begin
        pack[31:20] = s1_imm[11:0];
      end
      (s1_src == SRC_S): begin
        pack[31:25] = s1_imm[11:5];
        pack[11:7]  = s1_imm[4:0];
      end
      (s1_src == SRC_B): begin
        pack[31]    = s1_imm[12];
        pack[30:25] = s1_imm[10:5];
        pack[11:8]  = s1_imm[4:1];
        pack[7]     = s1_imm[11];
      end
      (s1_src == SRC_J): begin
        pack[31]    = s1_imm[20];
        pack[30:21] = s1_imm[10:1];
        pack[20]    = s1_imm[11];
        pack[19:12] = s1_imm[19:12];
      end
      (s1_src == SRC_U): begin
        pack[31:12] = s1_imm[31:12];
      end
      default: begin
        pack = s1_base;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_src   <= '0;
      s1_imm   <= '0;
      s1_base  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_err  <= in_err;
        s1_src  <= imm_src;
        s1_imm  <= imm;
        s1_base <= base_inst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_err   <= 1'b0;
      s2_inst  <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_err  <= s1_err;
        s2_inst <= pack;
      end
    end
  end

  assign out_valid = s2_valid;
  assign inst      = s2_inst;
  assign range_err = s2_err;

`ifdef IMM_ENCODER_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (s2_valid && out_ready && s2_err && !(&cnt)) begin
      cnt <= cnt + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = cnt;
`else
  assign err_cnt = '0;
`endif

endmodule
